// File: rtl/pc_gen_mt_pkg.sv
// pc_pkg -- shared constants, thread-id type and next-PC selector encoding for pc_gen_mt.
// Revision 1.0
`default_nettype none

package pc_pkg;

   localparam int                ADDR_W      = 32;
   localparam int                NUM_THREADS = 2;
   localparam int                INSTR_BYTES = 4;
   localparam logic [ADDR_W-1:0] RESET_VEC   = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] EXC_VEC     = 32'h0000_0180;

   // A single context still needs a 1-bit tid so the ports never collapse to zero width.
   function automatic int tid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int TID_W = tid_width(NUM_THREADS);

   typedef logic [TID_W-1:0] tid_t;

   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_SEQ   = 3'd1,
      SEL_REDIR = 3'd2,
      SEL_ERET  = 3'd3,
      SEL_EXC   = 3'd4
   } next_pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_gen_mt_rr_next_thread.sv
// rr_next_thread -- combinational round-robin pick of the next enabled thread after cur_tid.
// Revision 1.0
`default_nettype none

module rr_next_thread #(
   parameter int NUM_THREADS = 2,
   parameter int TID_W       = 1
) (
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic [TID_W-1:0]       cur_tid,
   output logic [TID_W-1:0]       next_tid,
   output logic                   any_en
);

   int               idx;
   logic [TID_W-1:0] idx_t;

   // Scan farthest-first so the nearest enabled successor is the last (winning) assignment;
   // offset NUM_THREADS lands back on cur_tid when it is the only enabled thread.
   always_comb begin
      next_tid = cur_tid;
      any_en   = |thread_en;
      idx      = 0;
      idx_t    = '0;
      for (int k = NUM_THREADS; k >= 1; k--) begin
         idx   = (int'(cur_tid) + k) % NUM_THREADS;
         idx_t = TID_W'(idx);
         if (thread_en[idx_t]) begin
            next_tid = idx_t;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_gen_mt.sv
// pc_gen_mt -- multi-thread fetch PC generator with round-robin select, redirect, exception and ERET.
// Revision 1.0. Optional PC_ALIGN_TRAP_EN: misaligned redirect/ERET targets trap and pulse align_trap.
`default_nettype none

module pc_gen_mt #(
   parameter int                           NUM_THREADS = pc_pkg::NUM_THREADS,
   parameter int                           ADDR_W      = pc_pkg::ADDR_W,
   parameter int                           INSTR_BYTES = pc_pkg::INSTR_BYTES,
   parameter logic [pc_pkg::ADDR_W-1:0]    RESET_VEC   = pc_pkg::RESET_VEC,
   parameter logic [pc_pkg::ADDR_W-1:0]    EXC_VEC     = pc_pkg::EXC_VEC,
   localparam int                          TID_W       = pc_pkg::tid_width(NUM_THREADS)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic                   fetch_ready,
   output logic                   fetch_valid,
   output logic [TID_W-1:0]       fetch_tid,
   output logic [ADDR_W-1:0]      fetch_pc,
   input  logic                   redir_valid,
   input  logic [TID_W-1:0]       redir_tid,
   input  logic [ADDR_W-1:0]      redir_target,
   input  logic                   exc_valid,
   input  logic [TID_W-1:0]       exc_tid,
   input  logic [ADDR_W-1:0]      exc_pc,
   input  logic                   eret_valid,
   input  logic [TID_W-1:0]       eret_tid,
`ifdef PC_ALIGN_TRAP_EN
   output logic                   align_trap,
`endif
   output logic [ADDR_W-1:0]      epc
);

   import pc_pkg::*;

   logic [TID_W-1:0]  tid_q;
   logic [TID_W-1:0]  next_tid;
   logic              any_en;
   logic              accept;
   logic [ADDR_W-1:0] pc_q  [NUM_THREADS];
   logic [ADDR_W-1:0] epc_q [NUM_THREADS];
   logic [ADDR_W-1:0] pc_d  [NUM_THREADS];
   logic [ADDR_W-1:0] epc_d [NUM_THREADS];
   next_pc_sel_e      sel   [NUM_THREADS];
`ifdef PC_ALIGN_TRAP_EN
   logic              trap_d;
`endif

   rr_next_thread #(
      .NUM_THREADS (NUM_THREADS),
      .TID_W       (TID_W)
   ) u_rr (
      .thread_en (thread_en),
      .cur_tid   (tid_q),
      .next_tid  (next_tid),
      .any_en    (any_en)
   );

   assign fetch_tid   = tid_q;
   assign fetch_pc    = pc_q[tid_q];
   assign epc         = epc_q[tid_q];
   assign fetch_valid = thread_en[tid_q];
   assign accept      = fetch_valid & fetch_ready;

   // Tid compares against in-range constants only, so out-of-range tids never match a thread.
   always_comb begin
`ifdef PC_ALIGN_TRAP_EN
      trap_d = 1'b0;
`endif
      for (int t = 0; t < NUM_THREADS; t++) begin
         sel[t]   = SEL_HOLD;
         pc_d[t]  = pc_q[t];
         epc_d[t] = epc_q[t];
         if (exc_valid && exc_tid == TID_W'(t)) begin
            sel[t]   = SEL_EXC;
            epc_d[t] = exc_pc;
         end else if (eret_valid && eret_tid == TID_W'(t)) begin
            sel[t] = SEL_ERET;
`ifdef PC_ALIGN_TRAP_EN
            if (epc_q[t][1:0] != 2'b00) begin
               sel[t] = SEL_EXC;
               trap_d = 1'b1;
            end
`endif
         end else if (redir_valid && redir_tid == TID_W'(t)) begin
            sel[t] = SEL_REDIR;
`ifdef PC_ALIGN_TRAP_EN
            if (redir_target[1:0] != 2'b00) begin
               sel[t]   = SEL_EXC;
               epc_d[t] = redir_target;
               trap_d   = 1'b1;
            end
`endif
         end else if (accept && tid_q == TID_W'(t)) begin
            sel[t] = SEL_SEQ;
         end

         case (sel[t])
            SEL_SEQ:   pc_d[t] = pc_q[t] + ADDR_W'(INSTR_BYTES);
            SEL_REDIR: pc_d[t] = redir_target;
            SEL_ERET:  pc_d[t] = epc_q[t];
            SEL_EXC:   pc_d[t] = EXC_VEC;
            default:   pc_d[t] = pc_q[t];
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         tid_q <= '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t]  <= RESET_VEC;
            epc_q[t] <= RESET_VEC;
         end
      end else begin
         if ((accept || !thread_en[tid_q]) && any_en) begin
            tid_q <= next_tid;
         end
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t]  <= pc_d[t];
            epc_q[t] <= epc_d[t];
         end
      end
   end

`ifdef PC_ALIGN_TRAP_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         align_trap <= 1'b0;
      end else begin
         align_trap <= trap_d;
      end
   end
`endif

endmodule

`default_nettype wire
